// File: rtl/matmul_pkg.sv
// Shared types and helpers for the systolic matrix multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package matmul_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Low bit of element (row, col) in a row-major packed n x n matrix of width-bit elements.
  function automatic int elem_lo(input int row, input int col, input int n, input int width);
    return (row * n + col) * width;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell of the systolic array; forwards a right and b down.
// Latency: one cycle from operand arrival to accumulator update and forwarding.
// Backpressure: none; advances whenever en is high, load has priority.
module systolic_pe #(
  parameter int DW     = 8,
  parameter int AW     = 18,
  parameter int SIGNED = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          en,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic [2*DW-1:0] prod;
  logic [AW-1:0]   prod_ext;

  // Operands are widened before the multiply so the low 2*DW bits are the exact product
  if (SIGNED != 0) begin : g_signed
    assign prod     = {{DW{a_in[DW-1]}}, a_in} * {{DW{b_in[DW-1]}}, b_in};
    assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
  end else begin : g_unsigned
    assign prod     = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
    assign prod_ext = {{(AW-2*DW){1'b0}}, prod};
  end

  // Accumulate and pass operands on; a load (start) resets the cell for a new product
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (load) begin
      acc   <= load_val;
      a_out <= '0;
      b_out <= '0;
    end else if (en) begin
      acc   <= acc + prod_ext;
      a_out <= a_in;
      b_out <= b_in;
    end
  end

endmodule

// File: rtl/systolic_matmul.sv
// N x N output-stationary systolic matrix multiply, optionally accumulating into C.
// Latency: done pulses 3N-1 cycles after the accepting start edge.
// Backpressure: start is ignored while busy; no stall once running.
module systolic_matmul
  import matmul_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DW     = DEF_DW,
  parameter int SIGNED = 0,
  localparam int AW    = 2*DW + clog2(N)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              accumulate,
  input  logic [N*N*DW-1:0] matrix_A,
  input  logic [N*N*DW-1:0] matrix_B,
  output logic              busy,
  output logic              done,
  output logic [N*N*AW-1:0] matrix_C
);

  localparam int            CW   = clog2(3*N-2);
  localparam logic [CW-1:0] LAST = CW'(3*N-3);

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [N*N*DW-1:0]        a_q, b_q;
  logic [N-1:0][DW-1:0]     edge_a, edge_b, edge_a_nxt, edge_b_nxt;
  logic [N-1:0][N:0][DW-1:0] a_h;
  logic [N:0][N-1:0][DW-1:0] b_v;
  logic [N*N*AW-1:0]        acc_flat;
  logic [N-1:0]             unused_tail;
  logic                     accept, run;

  assign accept = (state == S_IDLE) && start;
  assign run    = (state == S_RUN);

  // Edge values for the coming feed cycle t: row i sees A[i][t-i], column j sees B[t-j][j]
  always_comb begin
    int t, k;
    logic [N*N*DW-1:0] a_src, b_src;
    edge_a_nxt = '0;
    edge_b_nxt = '0;
    k     = 0;
    a_src = accept ? matrix_A : a_q;
    b_src = accept ? matrix_B : b_q;
    t     = accept ? 0 : int'(cnt) + 1;
    for (int i = 0; i < N; i++) begin
      k = t - i;
      if (k >= 0 && k < N) begin
        edge_a_nxt[i] = a_src[elem_lo(i, k, N, DW) +: DW];
        edge_b_nxt[i] = b_src[elem_lo(k, i, N, DW) +: DW];
      end
    end
  end

  // Skew passers: registered edge feed, zero whenever no operation is feeding
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      edge_a <= '0;
      edge_b <= '0;
    end else if (accept || run) begin
      edge_a <= edge_a_nxt;
      edge_b <= edge_b_nxt;
    end else begin
      edge_a <= '0;
      edge_b <= '0;
    end
  end

  genvar gi, gj;
  for (gi = 0; gi < N; gi++) begin : g_row
    assign a_h[gi][0]      = edge_a[gi];
    assign b_v[0][gi]      = edge_b[gi];
    assign unused_tail[gi] = ^{a_h[gi][N], b_v[N][gi]};
    for (gj = 0; gj < N; gj++) begin : g_col
      systolic_pe #(.DW(DW), .AW(AW), .SIGNED(SIGNED)) u_pe (
        .clock    (clock),
        .reset    (reset),
        .load     (accept),
        .load_val (accumulate ? matrix_C[elem_lo(gi, gj, N, AW) +: AW] : '0),
        .en       (run),
        .a_in     (a_h[gi][gj]),
        .b_in     (b_v[gi][gj]),
        .a_out    (a_h[gi][gj+1]),
        .b_out    (b_v[gi+1][gj]),
        .acc      (acc_flat[elem_lo(gi, gj, N, AW) +: AW])
      );
    end
  end

  // Control FSM: counts feed cycles and publishes the accumulators as the result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      matrix_C <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_RUN;
          busy  <= 1'b1;
          cnt   <= '0;
          a_q   <= matrix_A;
          b_q   <= matrix_B;
        end
        S_RUN: begin
          if (cnt == LAST) state <= S_DONE;
          else             cnt   <= cnt + CW'(1);
        end
        S_DONE: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          matrix_C <= acc_flat;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_matmul.sv
// Bench for systolic_matmul: unsigned and signed instances share stimulus, checked against a matrix-level model.
// Latency: expects done 3N-1 edges after an accepted start.
// Backpressure: starts issued while busy must be ignored by both instances.
module tb_systolic_matmul;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 18;
  localparam int VW = N*N*AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic accumulate = 1'b0;
  logic [N*N*DW-1:0] mat_a, mat_b;
  logic busy_u, done_u, busy_s, done_s;
  logic [VW-1:0] c_u, c_s;

  int opa[N][N];
  int opb[N][N];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Pack the integer operand tables onto the DUT buses
  always_comb begin
    mat_a = '0;
    mat_b = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mat_a[(r*N+c)*DW +: DW] = DW'(opa[r][c]);
        mat_b[(r*N+c)*DW +: DW] = DW'(opb[r][c]);
      end
  end

  systolic_matmul #(.N(N), .DW(DW), .SIGNED(0)) u_dut (
    .clock(clk), .reset(rst_n), .start(start), .accumulate(accumulate),
    .matrix_A(mat_a), .matrix_B(mat_b), .busy(busy_u), .done(done_u), .matrix_C(c_u));

  systolic_matmul #(.N(N), .DW(DW), .SIGNED(1)) u_dut_s (
    .clock(clk), .reset(rst_n), .start(start), .accumulate(accumulate),
    .matrix_A(mat_a), .matrix_B(mat_b), .busy(busy_s), .done(done_s), .matrix_C(c_s));

  function automatic void check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic logic [AW-1:0] el(input logic [VW-1:0] v, input int r, input int c);
    return v[(r*N+c)*AW +: AW];
  endfunction

  // Reference model: one matrix product element from the operand tables
  function automatic logic [AW-1:0] model_elem(input bit sgn, input int r, input int c, input logic [AW-1:0] base);
    longint s, av, bv;
    s = longint'(base);
    for (int k = 0; k < N; k++) begin
      av = opa[r][k];
      bv = opb[k][c];
      if (sgn && av > 127) av -= 256;
      if (sgn && bv > 127) bv -= 256;
      s += av * bv;
    end
    return AW'(s);
  endfunction

  logic [AW-1:0] exp_cu[N][N], exp_cs[N][N], pend_u[N][N], pend_s[N][N];
  bit exp_done, exp_busy, inflight;
  int since;

  // Transaction-level model: an accepted start yields a result 3N-1 edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight = 0; since = 0; exp_done = 0; exp_busy = 0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          exp_cu[r][c] = '0;
          exp_cs[r][c] = '0;
        end
    end else begin
      exp_done = 0;
      if (inflight) begin
        since++;
        if (since == 3*N-1) begin
          exp_cu = pend_u;
          exp_cs = pend_s;
          exp_done = 1;
          inflight = 0;
        end
      end else if (start) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            pend_u[r][c] = model_elem(1'b0, r, c, accumulate ? exp_cu[r][c] : '0);
            pend_s[r][c] = model_elem(1'b1, r, c, accumulate ? exp_cs[r][c] : '0);
          end
        inflight = 1;
        since = 0;
      end
      exp_busy = inflight;
    end
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin : cmp
    logic [VW-1:0] eu, es;
    eu = '0;
    es = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        eu[(r*N+c)*AW +: AW] = exp_cu[r][c];
        es[(r*N+c)*AW +: AW] = exp_cs[r][c];
      end
    check("done_u", done_u, exp_done);
    check("busy_u", busy_u, exp_busy);
    check("matrix_C_u", c_u, eu);
    check("done_s", done_s, exp_done);
    check("busy_s", busy_s, exp_busy);
    check("matrix_C_s", c_s, es);
  end

  task automatic launch(input bit acc);
    @(negedge clk);
    start = 1'b1;
    accumulate = acc;
    @(negedge clk);
    start = 1'b0;
    accumulate = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done_u) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within 40 cycles, required one");
    end
  endtask

  task automatic run_op(input bit acc, input string name);
    int lat;
    launch(acc);
    wait_done(lat);
    if (lat >= 0) check({name, "_latency"}, lat, 11);
  endtask

  task automatic set_ident_ramp();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        opa[r][c] = (r == c) ? 1 : 0;
        opb[r][c] = r*N + c;
      end
  endtask

  task automatic set_fill(input int av, input int bv);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        opa[r][c] = av;
        opb[r][c] = bv;
      end
  endtask

  task automatic set_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        opa[r][c] = int'($urandom_range(0, 255));
        opb[r][c] = int'($urandom_range(0, 255));
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    set_fill(0, 0);

    // Reset state
    @(negedge clk);
    check("reset_busy", busy_u, 0);
    check("reset_done", done_u, 0);
    check("reset_C", c_u, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Identity times ramp gives the ramp back
    set_ident_ramp();
    run_op(1'b0, "ident");
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        check("ident_C_u", el(c_u, r, c), AW'(r*N+c));
        check("ident_C_s", el(c_s, r, c), AW'(r*N+c));
        check("ident_model", exp_cu[r][c], AW'(r*N+c));
      end

    // Back-to-back accumulate doubles the result
    run_op(1'b1, "accum");
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        check("accum_C_u", el(c_u, r, c), AW'(2*(r*N+c)));

    // All-ones-byte operands: largest unsigned sum, (-1)*(-1) signed
    set_fill(255, 255);
    run_op(1'b0, "max");
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        check("max_C_u", el(c_u, r, c), 18'd260100);
        check("max_C_s", el(c_s, r, c), 18'd4);
      end

    // -1 times 2 summed four times
    set_fill(255, 2);
    run_op(1'b0, "neg");
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        check("neg_C_s", el(c_s, r, c), 18'h3FFF8);
        check("neg_C_u", el(c_u, r, c), 18'd2040);
        check("neg_model", exp_cs[r][c], 18'h3FFF8);
      end

    // A start pulsed during RUN with new operands is ignored
    set_ident_ramp();
    launch(1'b0);
    repeat (4) @(negedge clk);
    set_random();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("repulse_latency", lat, 6);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        check("repulse_C_u", el(c_u, r, c), AW'(r*N+c));

    // Reset in the middle of RUN aborts the operation
    set_random();
    launch(1'b0);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("abort_C", c_u, 0);
    check("abort_busy", busy_u, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done_u || done_s) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    set_ident_ramp();
    for (int c = 0; c < N; c++) opb[1][c] = 100 + c;
    run_op(1'b0, "after_reset");
    check("after_reset_C10", el(c_u, 1, 0), 18'd100);
    check("after_reset_C33", el(c_u, 3, 3), 18'd15);

    // Randomized operations, mixed accumulate, small idle gaps
    for (int n = 0; n < 10; n++) begin
      set_random();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(1'($urandom_range(0, 1)), "rand");
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
